// File: rtl/vacc_dump_if.sv
// Output stream of the accumulator readout: one {A,B} word pair per vector index.
// Latency: none; this is a bundle of wires.
// Backpressure: a beat transfers when dout_valid & dout_ready; the master holds it otherwise.
interface vacc_dump_if #(
  parameter int ACC_WIDTH = 12,
  parameter int VLB       = 5
);
  logic [2*ACC_WIDTH-1:0] dout;
  logic [VLB-1:0]         dout_idx;
  logic                   dout_valid;
  logic                   dout_ready;
  logic                   dout_last;

  modport master (
    output dout,
    output dout_idx,
    output dout_valid,
    output dout_last,
    input  dout_ready
  );

  modport slave (
    input  dout,
    input  dout_idx,
    input  dout_valid,
    input  dout_last,
    output dout_ready
  );
endinterface

// File: rtl/vacc_dump.sv
// Walks a completed accumulator buffer and streams {A[i],B[i]} for i = 0..VECTOR_LENGTH-1.
// Latency: acc_done to first dout_valid is RAM_LATENCY+2 clocks; one beat per clock after that.
// Backpressure: reads are issued only against free FIFO credit, so a stalled consumer stalls reads and nothing drops.
// Optional: define VACC_DUMP_FRAME_CNT_EN to add the 16-bit frame_cnt output.
module vacc_dump #(
  parameter int ACC_WIDTH     = 12,
  parameter int VECTOR_LENGTH = 32,
  parameter int RAM_LATENCY   = 2,
  parameter int FIFO_DEPTH    = 4
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             acc_done,
  input  logic                             acc_buf,
  output logic [$clog2(VECTOR_LENGTH)-1:0] ant_sel_a,
  output logic [$clog2(VECTOR_LENGTH)-1:0] ant_sel_b,
  output logic                             buf_sel,
  input  logic [ACC_WIDTH-1:0]             acc_dout_a,
  input  logic [ACC_WIDTH-1:0]             acc_dout_b,
  vacc_dump_if.master                      dout_if,
  output logic                             busy,
  output logic                             overrun
`ifdef VACC_DUMP_FRAME_CNT_EN
  ,
  output logic [15:0]                      frame_cnt
`endif
);

  localparam int VLB = $clog2(VECTOR_LENGTH);
  localparam int DW  = 2 * ACC_WIDTH;
  localparam int PW  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW  = $clog2(FIFO_DEPTH + 1);
  localparam int OW  = $clog2(FIFO_DEPTH + RAM_LATENCY + 2) + 1;

  localparam logic [VLB-1:0] LAST_IDX = VLB'(VECTOR_LENGTH - 1);
  localparam logic [PW-1:0]  LAST_PTR = PW'(FIFO_DEPTH - 1);

  typedef enum logic [1:0] {S_IDLE, S_DUMP, S_DRAIN} state_e;

  typedef struct packed {
    logic [VLB-1:0] idx;
    logic [DW-1:0]  dat;
  } beat_t;

  // Control FSM and registered read-side outputs
  state_e         state_q, state_d;
  logic           buf_sel_q, buf_sel_d;
  logic [VLB-1:0] ant_sel_q, ant_sel_d;
  logic [VLB-1:0] rd_idx_q, rd_idx_d;
  logic           addr_vld_q, addr_vld_d;
  logic           busy_q, busy_d;
  logic           overrun_q, overrun_d;

  // Read-latency tracking pipe: one slot per RAM pipeline stage
  logic [RAM_LATENCY-1:0] pipe_vld_q, pipe_vld_d;
  logic [VLB-1:0]         pipe_idx_q [RAM_LATENCY];
  logic [VLB-1:0]         pipe_idx_d [RAM_LATENCY];

  // Skid FIFO plus registered output beat
  beat_t          mem_q [FIFO_DEPTH];
  beat_t          mem_d [FIFO_DEPTH];
  logic [PW-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  beat_t          out_q, out_d;
  logic           out_vld_q, out_vld_d;
  logic           out_last_q, out_last_d;

  logic           fifo_push;
  logic           fifo_pop;
  logic [OW-1:0]  inflight;
  logic           credit_ok;
  logic           drain_ok;

  // Reads whose data has not yet landed in the FIFO: the address stage plus every RAM stage
  always_comb begin
    inflight = OW'(addr_vld_q);
    for (int i = 0; i < RAM_LATENCY; i++) begin
      inflight = inflight + OW'(pipe_vld_q[i]);
    end
  end

  // The output register refills from the FIFO whenever it is empty or being accepted this cycle
  assign fifo_push = pipe_vld_q[RAM_LATENCY-1];
  assign fifo_pop  = (cnt_q != '0) && (!out_vld_q || dout_if.dout_ready);

  // A new read may go out only if every outstanding word still has a FIFO slot once this cycle's pop is done
  assign credit_ok = ((OW'(cnt_q) + inflight - OW'(fifo_pop)) < OW'(FIFO_DEPTH));
  assign drain_ok  = (inflight == '0) && (cnt_q == '0);

  // FSM next state: IDLE exit issues index 0 directly so the first address is out on the same edge
  always_comb begin
    state_d    = state_q;
    buf_sel_d  = buf_sel_q;
    ant_sel_d  = ant_sel_q;
    rd_idx_d   = rd_idx_q;
    addr_vld_d = 1'b0;
    overrun_d  = overrun_q;
    case (state_q)
      S_IDLE: begin
        if (acc_done) begin
          state_d    = S_DUMP;
          buf_sel_d  = acc_buf;
          ant_sel_d  = '0;
          addr_vld_d = 1'b1;
          rd_idx_d   = VLB'(1);
        end
      end
      S_DUMP: begin
        if (acc_done) begin
          overrun_d = 1'b1;
        end
        if (credit_ok) begin
          ant_sel_d  = rd_idx_q;
          addr_vld_d = 1'b1;
          if (rd_idx_q == LAST_IDX) begin
            state_d = S_DRAIN;
          end else begin
            rd_idx_d = rd_idx_q + 1'b1;
          end
        end
      end
      S_DRAIN: begin
        // An acc_done on the exit edge still finds us busy and is dropped
        if (acc_done) begin
          overrun_d = 1'b1;
        end
        if (drain_ok) begin
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
    busy_d = (state_d != S_IDLE);
  end

  // Shift the issued index down the latency pipe in step with the RAM
  always_comb begin
    pipe_vld_d[0] = addr_vld_q;
    pipe_idx_d[0] = ant_sel_q;
    for (int i = 1; i < RAM_LATENCY; i++) begin
      pipe_vld_d[i] = pipe_vld_q[i-1];
      pipe_idx_d[i] = pipe_idx_q[i-1];
    end
  end

  // FIFO write from the pipe tail, read into the output register
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (fifo_push) begin
      mem_d[wr_ptr_q] = '{idx: pipe_idx_q[RAM_LATENCY-1], dat: {acc_dout_a, acc_dout_b}};
      wr_ptr_d        = (wr_ptr_q == LAST_PTR) ? '0 : wr_ptr_q + 1'b1;
    end
    if (fifo_pop) begin
      rd_ptr_d = (rd_ptr_q == LAST_PTR) ? '0 : rd_ptr_q + 1'b1;
    end
    cnt_d = cnt_q + CW'(fifo_push) - CW'(fifo_pop);
  end

  // Output beat holds while stalled, reloads on pop, and empties once accepted with nothing behind it
  always_comb begin
    out_d      = out_q;
    out_vld_d  = out_vld_q;
    out_last_d = out_last_q;
    if (fifo_pop) begin
      out_d      = mem_q[rd_ptr_q];
      out_vld_d  = 1'b1;
      out_last_d = (mem_q[rd_ptr_q].idx == LAST_IDX);
    end else if (out_vld_q && dout_if.dout_ready) begin
      out_vld_d  = 1'b0;
      out_last_d = 1'b0;
    end
  end

  // Control and datapath registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      buf_sel_q  <= 1'b0;
      ant_sel_q  <= '0;
      rd_idx_q   <= '0;
      addr_vld_q <= 1'b0;
      busy_q     <= 1'b0;
      overrun_q  <= 1'b0;
      pipe_vld_q <= '0;
      for (int i = 0; i < RAM_LATENCY; i++) begin
        pipe_idx_q[i] <= '0;
      end
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      cnt_q      <= '0;
      out_q      <= '0;
      out_vld_q  <= 1'b0;
      out_last_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      buf_sel_q  <= buf_sel_d;
      ant_sel_q  <= ant_sel_d;
      rd_idx_q   <= rd_idx_d;
      addr_vld_q <= addr_vld_d;
      busy_q     <= busy_d;
      overrun_q  <= overrun_d;
      pipe_vld_q <= pipe_vld_d;
      pipe_idx_q <= pipe_idx_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      cnt_q      <= cnt_d;
      out_q      <= out_d;
      out_vld_q  <= out_vld_d;
      out_last_q <= out_last_d;
    end
  end

  // FIFO storage; validity is carried entirely by the pointers and count
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

`ifdef VACC_DUMP_FRAME_CNT_EN
  logic [15:0] frame_cnt_q, frame_cnt_d;

  // One count per fully delivered dump, wrapping naturally at 16 bits
  always_comb begin
    frame_cnt_d = frame_cnt_q;
    if (out_vld_q && dout_if.dout_ready && out_last_q) begin
      frame_cnt_d = frame_cnt_q + 16'd1;
    end
  end

  // Frame counter register
  always_ff @(posedge clk) begin
    if (rst) begin
      frame_cnt_q <= '0;
    end else begin
      frame_cnt_q <= frame_cnt_d;
    end
  end

  assign frame_cnt = frame_cnt_q;
`endif

  assign ant_sel_a          = ant_sel_q;
  assign ant_sel_b          = ant_sel_q;
  assign buf_sel            = buf_sel_q;
  assign busy               = busy_q;
  assign overrun            = overrun_q;
  assign dout_if.dout       = out_q.dat;
  assign dout_if.dout_idx   = out_q.idx;
  assign dout_if.dout_valid = out_vld_q;
  assign dout_if.dout_last  = out_last_q;

endmodule

// File: tb/tb_vacc_dump.sv
// Bench for vacc_dump: a two-buffer BRAM model with two-clock read latency feeds the DUT;
// expected beats are queued when a dump is started and checked by an independent monitor.
module tb_vacc_dump;

  logic        clk;
  logic        rst;
  logic        acc_done;
  logic        acc_buf;
  logic [4:0]  ant_sel_a;
  logic [4:0]  ant_sel_b;
  logic        buf_sel;
  logic [11:0] acc_dout_a;
  logic [11:0] acc_dout_b;
  logic        busy;
  logic        overrun;
`ifdef VACC_DUMP_FRAME_CNT_EN
  logic [15:0] frame_cnt;
`endif

  vacc_dump_if #(.ACC_WIDTH(12), .VLB(5)) dif ();

  vacc_dump #(
    .ACC_WIDTH(12), .VECTOR_LENGTH(32), .RAM_LATENCY(2), .FIFO_DEPTH(4)
  ) dut (
    .clk(clk), .rst(rst), .acc_done(acc_done), .acc_buf(acc_buf),
    .ant_sel_a(ant_sel_a), .ant_sel_b(ant_sel_b), .buf_sel(buf_sel),
    .acc_dout_a(acc_dout_a), .acc_dout_b(acc_dout_b),
    .dout_if(dif.master), .busy(busy), .overrun(overrun)
`ifdef VACC_DUMP_FRAME_CNT_EN
    , .frame_cnt(frame_cnt)
`endif
  );

  typedef struct packed {
    logic [23:0] dat;
    logic [4:0]  idx;
    logic        last;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  int   beat_cnt = 0;
  bit   bp_mode = 0;

  // Buffer contents: buffer 1 A=i, B=F00+i; buffer 0 A=0A0+i, B=500+i
  logic [11:0] ram_a [2][32];
  logic [11:0] ram_b [2][32];
  logic [4:0]  addr_r;
  logic        bsel_r;

  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end

  initial begin
    for (int i = 0; i < 32; i++) begin
      ram_a[1][i] = 12'(i);
      ram_b[1][i] = 12'hF00 + 12'(i);
      ram_a[0][i] = 12'h0A0 + 12'(i);
      ram_b[0][i] = 12'h500 + 12'(i);
    end
  end

  // Address register then output register: two clocks from ant_sel to data
  always @(posedge clk) begin
    addr_r     <= ant_sel_a;
    bsel_r     <= buf_sel;
    acc_dout_a <= ram_a[bsel_r][addr_r];
    acc_dout_b <= ram_b[bsel_r][addr_r];
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic push_dump(input logic b);
    exp_t e;
    for (int i = 0; i < 32; i++) begin
      e.idx  = 5'(i);
      e.last = (i == 31);
      e.dat  = b ? {12'(i), 12'hF00 + 12'(i)} : {12'h0A0 + 12'(i), 12'h500 + 12'(i)};
      exp_q.push_back(e);
    end
  endtask

  task automatic start_dump(input logic b, input bit accept);
    @(posedge clk); #1;
    acc_done = 1'b1;
    acc_buf  = b;
    if (accept) push_dump(b);
    @(posedge clk); #1;
    acc_done = 1'b0;
  endtask

  task automatic wait_done(input string name, input int budget);
    int n;
    n = 0;
    while ((exp_q.size() != 0 || busy || dif.dout_valid) && n < budget) begin
      @(posedge clk); #1;
      n++;
    end
    chk({name, "_left"}, 64'(exp_q.size()), 64'd0);
    chk({name, "_busy"}, 64'(busy), 64'd0);
  endtask

  // Consumer ready: always high, or ~30% duty under backpressure
  initial begin
    dif.dout_ready = 1'b1;
    forever begin
      @(posedge clk); #1;
      dif.dout_ready = bp_mode ? ($urandom_range(0, 99) < 30) : 1'b1;
    end
  end

  // Monitor: pops expected beats on every handshake and checks hold-while-stalled
  initial begin : monitor
    exp_t        e;
    logic [29:0] prev;
    bit          prev_stall;
    prev_stall = 0;
    prev = '0;
    forever begin
      @(negedge clk);
      if (rst) begin
        prev_stall = 0;
      end else begin
        if (prev_stall) begin
          chk("stall_valid", 64'(dif.dout_valid), 64'd1);
          chk("stall_hold", 64'({dif.dout, dif.dout_idx, dif.dout_last}), 64'(prev));
        end
        if (dif.dout_valid && dif.dout_ready) begin
          beat_cnt++;
          checks++;
          if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL stray_beat: got idx %0d with none expected", dif.dout_idx);
          end else begin
            e = exp_q.pop_front();
            if ({dif.dout, dif.dout_idx, dif.dout_last} !== {e.dat, e.idx, e.last}) begin
              errors++;
              $display("FAIL beat: got dat=%0h idx=%0d last=%0b expected dat=%0h idx=%0d last=%0b",
                       dif.dout, dif.dout_idx, dif.dout_last, e.dat, e.idx, e.last);
            end
          end
        end
        prev_stall = dif.dout_valid && !dif.dout_ready;
        prev = {dif.dout, dif.dout_idx, dif.dout_last};
      end
    end
  end

  initial begin : watchdog
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin : stim
    int lat;
    int base;
    int n;
    bit saw_valid;
    rst = 1'b1;
    acc_done = 1'b0;
    acc_buf = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_ant_a", 64'(ant_sel_a), 64'd0);
    chk("rst_ant_b", 64'(ant_sel_b), 64'd0);
    chk("rst_buf_sel", 64'(buf_sel), 64'd0);
    chk("rst_dout", 64'(dif.dout), 64'd0);
    chk("rst_idx", 64'(dif.dout_idx), 64'd0);
    chk("rst_valid", 64'(dif.dout_valid), 64'd0);
    chk("rst_last", 64'(dif.dout_last), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_overrun", 64'(overrun), 64'd0);
`ifdef VACC_DUMP_FRAME_CNT_EN
    chk("rst_frame_cnt", 64'(frame_cnt), 64'd0);
`endif
    rst = 1'b0;
    repeat (2) @(posedge clk);

    // Basic dump from buffer 1, with an acc_done landing on the DRAIN exit edge
    base = beat_cnt;
    start_dump(1'b1, 1'b1);
    chk("k_busy", 64'(busy), 64'd1);
    chk("k_ant_a", 64'(ant_sel_a), 64'd0);
    chk("k_ant_b", 64'(ant_sel_b), 64'd0);
    chk("k_buf_sel", 64'(buf_sel), 64'd1);
    lat = 0;
    while (!dif.dout_valid && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    chk("first_valid_lat", 64'(lat), 64'd4);
    while (lat < 35) begin
      @(posedge clk); #1;
      lat++;
    end
    chk("busy_at_35", 64'(busy), 64'd1);
    acc_done = 1'b1;
    acc_buf = 1'b0;
    @(posedge clk); #1;
    acc_done = 1'b0;
    chk("busy_at_36", 64'(busy), 64'd0);
    chk("drain_exit_overrun", 64'(overrun), 64'd1);
    chk("drain_exit_buf_sel", 64'(buf_sel), 64'd1);
    wait_done("basic", 200);
    repeat (10) @(posedge clk);
    #1;
    chk("basic_beats", 64'(beat_cnt - base), 64'd32);

    // Reset in the middle of a dump
    base = beat_cnt;
    start_dump(1'b1, 1'b1);
    n = 0;
    while ((beat_cnt - base) < 15 && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    chk("rst_mid_beats", 64'(beat_cnt - base), 64'd15);
    rst = 1'b1;
    @(posedge clk); #1;
    chk("rst_mid_valid", 64'(dif.dout_valid), 64'd0);
    chk("rst_mid_busy", 64'(busy), 64'd0);
    chk("rst_mid_overrun", 64'(overrun), 64'd0);
    chk("rst_mid_buf_sel", 64'(buf_sel), 64'd0);
    exp_q.delete();
    rst = 1'b0;
    saw_valid = 0;
    repeat (40) begin
      @(posedge clk); #1;
      if (dif.dout_valid) saw_valid = 1;
    end
    chk("rst_mid_quiet", 64'(saw_valid), 64'd0);

    // Overrun: a second acc_done ten cycles into a dump is ignored
    base = beat_cnt;
    start_dump(1'b1, 1'b1);
    repeat (9) @(posedge clk);
    start_dump(1'b0, 1'b0);
    chk("ovr_flag", 64'(overrun), 64'd1);
    chk("ovr_buf_sel", 64'(buf_sel), 64'd1);
    wait_done("ovr", 200);
    repeat (10) @(posedge clk);
    #1;
    chk("ovr_beats", 64'(beat_cnt - base), 64'd32);
    base = beat_cnt;
    start_dump(1'b0, 1'b1);
    chk("ovr_next_buf_sel", 64'(buf_sel), 64'd0);
    wait_done("ovr_next", 200);
    chk("ovr_next_beats", 64'(beat_cnt - base), 64'd32);
    chk("ovr_sticky", 64'(overrun), 64'd1);

    // Buffer alternation 0,1,0 from a fresh reset
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    for (int d = 0; d < 3; d++) begin
      base = beat_cnt;
      start_dump(logic'(d == 1), 1'b1);
      chk("alt_buf_sel", 64'(buf_sel), 64'(d == 1));
      wait_done("alt", 200);
      repeat (2) @(posedge clk);
      #1;
      chk("alt_beats", 64'(beat_cnt - base), 64'd32);
`ifdef VACC_DUMP_FRAME_CNT_EN
      chk("alt_frame_cnt", 64'(frame_cnt), 64'(d + 1));
`endif
    end

    // Backpressure at ~30% ready
    bp_mode = 1;
    base = beat_cnt;
    start_dump(1'b0, 1'b1);
    wait_done("bp", 3000);
    bp_mode = 0;
    repeat (5) @(posedge clk);
    #1;
    chk("bp_beats", 64'(beat_cnt - base), 64'd32);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/vacc_dump.md
# vacc_dump

Readout stage downstream of the X-engine vector accumulator. On each completed accumulation it walks every vector index of the finished BRAM buffer. It reads both accumulator ports (A and B) at that index and streams the pair out over a valid/ready interface with backpressure, while the accumulator keeps integrating into the other buffer. It also drives the accumulator's read-side controls: antenna select A/B and buffer select.

## Interface
Parameters:
- ACC_WIDTH, 12, width of one accumulated word (INPUT_WIDTH + ACC_LEN_BITS of the accumulator)
- VECTOR_LENGTH, 32, number of vector indices per buffer; power of two, ≥ 2
- RAM_LATENCY, 2, clocks from read address to read data (BRAM with output register)
- FIFO_DEPTH, 4, output skid FIFO entries; must be ≥ RAM_LATENCY + 2

Ports (VLB = log2(VECTOR_LENGTH)):
- clk  in  1  single clock; all logic is rising-edge
- rst  in  1  synchronous, active-high reset
- acc_done  in  1  one-cycle pulse: the buffer named by acc_buf is complete
- acc_buf  in  1  index of the completed buffer, sampled with acc_done
- ant_sel_a  out  VLB  read address to accumulator RAM A
- ant_sel_b  out  VLB  read address to accumulator RAM B
- buf_sel  out  1  buffer read index to accumulator
- acc_dout_a  in  ACC_WIDTH  read data from RAM A
- acc_dout_b  in  ACC_WIDTH  read data from RAM B
- dout  out  2*ACC_WIDTH  {acc_dout_a, acc_dout_b}; A in the MSBs
- dout_idx  out  VLB  vector index of dout
- dout_valid  out  1  dout/dout_idx/dout_last valid
- dout_ready  in  1  consumer accepts when dout_valid & dout_ready
- dout_last  out  1  marks index VECTOR_LENGTH-1
- busy  out  1  high in DUMP or DRAIN
- overrun  out  1  sticky: acc_done arrived while busy

## Operation
- FSM states:
  - IDLE: acc_done → latch acc_buf into buf_sel, clear read index, go to DUMP.
  - DUMP: issue reads; after the read of index VECTOR_LENGTH-1 is issued → DRAIN.
  - DRAIN: wait until no reads are in flight and the FIFO is empty → IDLE.
- Read issue: in DUMP, a read of index i drives ant_sel_a = ant_sel_b = i for one cycle.
  - A read is issued only when fifo_count + inflight < FIFO_DEPTH (credit rule). This guarantees no returning data is ever dropped.
  - inflight is tracked by a RAM_LATENCY-deep valid/index shift pipe.
- Capture: read data is written into the FIFO with its index when the pipe's tail is valid.
- Output: FIFO head drives dout, dout_idx and dout_last. The FIFO pops on dout_valid & dout_ready.
- Emission order is strictly 0..VECTOR_LENGTH-1, exactly once per acc_done.
- buf_sel holds the latched value from IDLE exit until the next accepted acc_done. It does not change during DUMP or DRAIN.
- acc_done while busy: ignored, overrun ← 1, current dump unaffected. overrun clears only on rst.
- acc_done in the same cycle DRAIN exits to IDLE counts as busy (overrun, ignored).
- The index counter is VLB bits and stops at the last index; it does not wrap within one dump.
- dout_ready low indefinitely: issue stalls by the credit rule, data is held stable, nothing is lost.

## Timing
- Reset values:
  - state IDLE
  - ant_sel_a = ant_sel_b = 0, buf_sel = 0
  - dout = 0, dout_idx = 0, dout_valid = 0, dout_last = 0
  - busy = 0, overrun = 0
  - FIFO and in-flight pipe are emptied.
- rst mid-dump: everything returns to reset values on the next edge. Partial output is abandoned and no further dout_valid is produced.
- acc_done sampled high at edge k:
  - busy = 1 and first read address are presented after edge k.
  - Data is captured at edge k+1+RAM_LATENCY.
  - dout_valid = 1 after edge k+2+RAM_LATENCY (4 cycles with defaults).
- With dout_ready held high, one word is issued and emitted per cycle. The full dump takes VECTOR_LENGTH + RAM_LATENCY + 2 cycles from acc_done to busy = 0.
- dout, dout_idx and dout_last are stable while dout_valid & !dout_ready.
- busy falls on the edge after the final FIFO pop.

## Configuration
- Macro VACC_DUMP_FRAME_CNT_EN.
  - Defined: adds output frame_cnt [15:0], reset 0. It increments (wrapping at 16'hFFFF → 0) on each accepted dout_last beat, giving a per-dump sequence number for downstream packetisers.
  - Undefined: the port and counter are absent; all other behaviour is identical.

## Test plan
- Basic dump: preload A[i] = i, B[i] = 12'hF00+i in buffer 1; pulse acc_done with acc_buf = 1 and dout_ready = 1.
  - 32 beats, dout = {i, 12'hF00+i}, dout_idx = i, buf_sel = 1.
  - First valid exactly 4 cycles after acc_done; dout_last only on i = 31; busy low 36 cycles after acc_done.
- Backpressure: random dout_ready at 30% duty.
  - All 32 indices are delivered in order with no duplicates.
  - Outputs are stable while stalled, and the FIFO never exceeds 4 entries.
- Overrun: pulse acc_done again 10 cycles into a dump.
  - overrun = 1 and the dump still emits exactly 32 beats.
  - A further acc_done after busy falls starts a new dump normally.
- Reset mid-dump: assert rst at beat 15.
  - Next cycle dout_valid = 0, busy = 0, overrun = 0, buf_sel = 0.
  - No valid output until a new acc_done.
- Buffer alternation: three dumps with acc_buf = 0, 1, 0.
  - buf_sel follows 0, 1, 0 and data matches each buffer's contents.
  - With VACC_DUMP_FRAME_CNT_EN, frame_cnt reads 1, 2, 3.
